dx_operand_latch: RTL
=====================

// Module: dx_operand_latch
// PURPOSE
//  Decode->execute pipeline stage feeding the ALU logic units (AND/OR/add/shift) their A/B operands and opcode.
//  2-entry skid buffer with valid/ready handshake; in_ready is purely registered (no comb path from out_ready).
//  Supports synchronous flush for branch mispredict/jump squash. Optional operand forwarding at capture.
// PARAMETERS
//  DATA_W   32  operand width (A, B, forward data)
//  OP_W     5   ALU opcode width
//  REG_W    5   register tag width (rd/rs1/rs2)
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  flush      in   1       sync squash of all held entries
//  in_valid   in   1       decode presents an operation
//  in_ready   out  1       stage can accept (registered)
//  in_a/in_b  in   DATA_W  operands from regfile
//  in_op      in   OP_W    ALU opcode
//  in_shamt   in   5       shift amount
//  in_rd      in   REG_W   destination tag
//  in_rs1/in_rs2 in REG_W  source tags (used only with forwarding)
//  out_valid  out  1       operation available to execute
//  out_ready  in   1       execute consumes this cycle
//  out_a/out_b out DATA_W  operands to ALU
//  out_op/out_shamt/out_rd out  as inputs
//  occupancy  out  2       entries held (0..2)
// BEHAVIOUR
//  States EMPTY(0), ONE(1: main valid), TWO(2: main+skid valid). in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
//  EMPTY: in_fire -> ONE (payload to main). ONE: in_fire&!out_fire -> TWO (payload to skid);
//   out_fire&!in_fire -> EMPTY; both -> ONE (new payload to main). TWO: out_fire -> ONE (skid moves to main); in_fire impossible.
//  in_ready = (state!=TWO), registered; out_valid = (state!=EMPTY); out_* always driven from main register.
//  Latency: in_fire in cycle N -> out_valid in cycle N+1; zero-bubble throughput 1 op/cycle when out_ready held high.
//  Order preserved: skid always older than any later capture; never overwrite a valid unconsumed entry.
//  flush: next state EMPTY regardless of in_fire/out_fire same cycle; the input presented that cycle is dropped;
//   an out_fire in the flush cycle still completes (execute already sampled). in_ready=1 the cycle after.
//  Reset (async, any time incl. mid-transfer): state EMPTY, out_valid=0, in_ready=1, occupancy=0, all payload regs=0.
//  Payload registers update only on capture (no toggling when idle); out_* stable while out_valid&!out_ready.
//  Widths: no arithmetic on data; occupancy = state encoding.
// CONFIGURATION
//  DX_FWD_EN defined: extra ports xm_wen, xm_rd[REG_W], xm_data[DATA_W], mw_wen, mw_rd, mw_data. At capture,
//   A = (xm_wen & xm_rd==in_rs1 & in_rs1!=0) ? xm_data : (mw match ? mw_data : in_a); B likewise with in_rs2; xm wins over mw.
//   Tag 0 never forwarded. Forwarding evaluated only in the in_fire cycle, not while held.
//  DX_FWD_EN undefined: ports absent; in_rs1/in_rs2 ignored; operands captured verbatim.
// STRUCTURE
//  Shared package alu_pkg: DATA_W/OP_W/REG_W constants, ALU opcode localparams, state encoding (ST_EMPTY/ST_ONE/ST_TWO).
//  One sub-module: dx_fwd_mux (combinational 3:1 operand select per source), instantiated twice under DX_FWD_EN.
// TESTING
//  Reset: assert reset_n=0 mid-TWO -> out_valid=0, in_ready=1, occupancy=0 immediately (async).
//  Stream 8 ops, out_ready=1 -> outputs appear 1 cycle later, in order, one per cycle, occupancy stays 1.
//  out_ready=0, push A=0xFFFF0000 B=0x0F0F0F0F then second op -> occupancy=2, in_ready=0; release -> first then second.
//  State TWO, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0; dropped op never appears.
//  ONE, in_fire and out_fire same cycle -> occupancy stays 1, out_a = new A next cycle.
//  DX_FWD_EN: in_rs1=3, xm_wen=1 xm_rd=3 xm_data=0xDEADBEEF, mw_rd=3 -> out_a=0xDEADBEEF; rs1=0 -> in_a kept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: operand/opcode/tag widths, ALU opcodes
// and the state encoding used by the decode->execute operand latch.
package alu_pkg;

   localparam int ALU_DATA_W  = 32;
   localparam int ALU_OP_W    = 5;
   localparam int ALU_REG_W   = 5;
   localparam int ALU_SHAMT_W = 5;

   localparam logic [ALU_OP_W-1:0] OP_AND = 5'd0;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 5'd1;
   localparam logic [ALU_OP_W-1:0] OP_ADD = 5'd2;
   localparam logic [ALU_OP_W-1:0] OP_SLL = 5'd3;
   localparam logic [ALU_OP_W-1:0] OP_SRL = 5'd4;

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } dx_state_e;

endpackage

// File: rtl/dx_fwd_mux.sv
// Per-source operand select: newest in-flight writer (X/M) beats the older one (M/W),
// which beats the register-file value. Tag 0 is hardwired and never forwarded.
module dx_fwd_mux #(
   parameter int DATA_W = alu_pkg::ALU_DATA_W,
   parameter int REG_W  = alu_pkg::ALU_REG_W
) (
   input  logic [REG_W-1:0]  src_tag,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              xm_wen,
   input  logic [REG_W-1:0]  xm_rd,
   input  logic [DATA_W-1:0] xm_data,
   input  logic              mw_wen,
   input  logic [REG_W-1:0]  mw_rd,
   input  logic [DATA_W-1:0] mw_data,
   output logic [DATA_W-1:0] fwd_data
);

   // NOTE: every output of an always_comb gets a default first so no path infers a latch.
   always_comb begin
      fwd_data = reg_data;
      if (src_tag != '0) begin
         if (xm_wen && (xm_rd == src_tag)) begin
            fwd_data = xm_data;
         end else if (mw_wen && (mw_rd == src_tag)) begin
            fwd_data = mw_data;
         end
      end
   end

endmodule

// File: rtl/dx_operand_latch.sv
// Decode->execute operand stage: 2-entry skid buffer with registered in_ready and sync flush.
// Define DX_FWD_EN to add X/M and M/W operand forwarding at capture time.
module dx_operand_latch
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W,
   parameter int REG_W  = ALU_REG_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [OP_W-1:0]   in_op,
   input  logic [4:0]        in_shamt,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
`ifdef DX_FWD_EN
   input  logic              xm_wen,
   input  logic [REG_W-1:0]  xm_rd,
   input  logic [DATA_W-1:0] xm_data,
   input  logic              mw_wen,
   input  logic [REG_W-1:0]  mw_rd,
   input  logic [DATA_W-1:0] mw_data,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [OP_W-1:0]   out_op,
   output logic [4:0]        out_shamt,
   output logic [REG_W-1:0]  out_rd,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [4:0]        shamt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } payload_t;

   dx_state_e   state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   payload_t    main_q, main_d;
   payload_t    skid_q, skid_d;

   logic [DATA_W-1:0] cap_a;
   logic [DATA_W-1:0] cap_b;
   payload_t          cap;
   logic              in_fire;
   logic              out_fire;

`ifdef DX_FWD_EN
   dx_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_a (
      .src_tag  (in_rs1),
      .reg_data (in_a),
      .xm_wen   (xm_wen),
      .xm_rd    (xm_rd),
      .xm_data  (xm_data),
      .mw_wen   (mw_wen),
      .mw_rd    (mw_rd),
      .mw_data  (mw_data),
      .fwd_data (cap_a)
   );

   dx_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_b (
      .src_tag  (in_rs2),
      .reg_data (in_b),
      .xm_wen   (xm_wen),
      .xm_rd    (xm_rd),
      .xm_data  (xm_data),
      .mw_wen   (mw_wen),
      .mw_rd    (mw_rd),
      .mw_data  (mw_data),
      .fwd_data (cap_b)
   );
`else
   // Source tags only matter when forwarding is built in.
   logic unused_src_tags;
   assign unused_src_tags = ^{in_rs1, in_rs2};
   assign cap_a = in_a;
   assign cap_b = in_b;
`endif

   assign cap      = '{op: in_op, shamt: in_shamt, rd: in_rd, a: cap_a, b: cap_b};
   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // Main always holds the oldest entry; skid only fills while main is stalled.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_d  = cap;
               end
            end
            ST_ONE: begin
               if (in_fire && !out_fire) begin
                  state_d = ST_TWO;
                  skid_d  = cap;
               end else if (in_fire && out_fire) begin
                  main_d  = cap;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   // NOTE: payload registers are reset too, so out_* read zero before the first capture.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_a     = main_q.a;
   assign out_b     = main_q.b;
   assign out_op    = main_q.op;
   assign out_shamt = main_q.shamt;
   assign out_rd    = main_q.rd;
   assign occupancy = state_q;

endmodule
